// File: rtl/videocard_mem_arbiter_if.sv
// Bus bundle between the videocard memory arbiter and its neighbours: HPS
// data slave, control slave, compute core handshake and the single-port RAM.
// master = the surrounding system (HPS bridge, core, RAM); slave = arbiter.
interface videocard_mem_arbiter_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 16
);
    // HPS Avalon-MM data slave
    logic [ADDR_W-1:0] host_address;
    logic [WIDTH-1:0]  host_writedata;
    logic              host_write;
    logic              host_read;
    logic              host_waitrequest;
    logic [WIDTH-1:0]  host_readdata;
    logic              host_readdatavalid;

    // Compute core memory port
    logic              core_req;
    logic [ADDR_W-1:0] core_address;
    logic [WIDTH-1:0]  core_wdata;
    logic              core_wren;
    logic              core_gnt;
    logic [WIDTH-1:0]  core_rdata;
    logic              core_rvalid;

    // Control slave and run handshake
    logic              ctrl_address;
    logic              ctrl_write;
    logic [WIDTH-1:0]  ctrl_writedata;
    logic [WIDTH-1:0]  ctrl_readdata;
    logic              core_start;
    logic              core_done;

    // RAM port
    logic [ADDR_W-1:0] ram_address;
    logic [WIDTH-1:0]  ram_data;
    logic              ram_wren;
    logic [WIDTH-1:0]  ram_q;

    modport master (
        output host_address, host_writedata, host_write, host_read,
        input  host_waitrequest, host_readdata, host_readdatavalid,
        output core_req, core_address, core_wdata, core_wren,
        input  core_gnt, core_rdata, core_rvalid,
        output ctrl_address, ctrl_write, ctrl_writedata,
        input  ctrl_readdata, core_start,
        output core_done,
        input  ram_address, ram_data, ram_wren,
        output ram_q
    );

    modport slave (
        input  host_address, host_writedata, host_write, host_read,
        output host_waitrequest, host_readdata, host_readdatavalid,
        input  core_req, core_address, core_wdata, core_wren,
        output core_gnt, core_rdata, core_rvalid,
        input  ctrl_address, ctrl_write, ctrl_writedata,
        output ctrl_readdata, core_start,
        input  core_done,
        output ram_address, ram_data, ram_wren,
        input  ram_q
    );
endinterface

// File: rtl/videocard_mem_arbiter.sv
// Videocard RAM arbiter and run-control FSM.
// Shares the single-port RAM between the HPS slave and the compute core; the
// core may only touch RAM while the FSM is in RUN. Reads return one cycle
// after grant, tagged with their owner.
// Optional build macro ARB_HOST_PRIORITY_EN: host wins every tie in RUN
// instead of round-robin.
module videocard_mem_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_sink_reset_n,
    videocard_mem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic GNT_HOST = 1'b0;
    localparam logic GNT_CORE = 1'b1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       start_nxt;
    logic       core_start_q;
    logic       last_grant;
    logic       host_rd_tag;
    logic       core_rd_tag;

    logic       start_wr;
    logic       ack_wr;
    logic       host_req;
    logic       host_grant;
    logic       core_grant;
    logic       unused_ctrl_bits;

    assign start_wr = bus.ctrl_write & ~bus.ctrl_address & bus.ctrl_writedata[0];
    assign ack_wr   = bus.ctrl_write &  bus.ctrl_address;
    assign host_req = bus.host_write | bus.host_read;
    assign unused_ctrl_bits = ^bus.ctrl_writedata[WIDTH-1:1];

    // Run-control state register and start pulse
    always_ff @(posedge clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state        <= ST_IDLE;
            core_start_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            core_start_q <= start_nxt;
        end
    end

    // Run-control next state: start from IDLE/DONE, done in RUN, ack in DONE
    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_wr) begin
                    state_nxt = ST_RUN;
                    start_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.core_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start_wr) begin
                    state_nxt = ST_RUN;
                    start_nxt = 1'b1;
                end else if (ack_wr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status readback: address 1 reports {DONE, RUN}
    always_comb begin
        bus.ctrl_readdata = '0;
        if (bus.ctrl_address) begin
            bus.ctrl_readdata = WIDTH'({state == ST_DONE, state == ST_RUN});
        end
    end

    // Grant: host exclusive outside RUN, arbitrated tie-break inside RUN
    always_comb begin
        host_grant = 1'b0;
        core_grant = 1'b0;
        if (state != ST_RUN) begin
            host_grant = host_req;
        end else begin
`ifdef ARB_HOST_PRIORITY_EN
            host_grant = host_req;
            core_grant = bus.core_req & ~host_req;
`else
            if (host_req && bus.core_req) begin
                core_grant = (last_grant == GNT_HOST);
                host_grant = (last_grant == GNT_CORE);
            end else begin
                host_grant = host_req;
                core_grant = bus.core_req;
            end
`endif
        end
    end

    // RAM mux: winner drives the port, host address parks when idle
    always_comb begin
        bus.ram_address = bus.host_address;
        bus.ram_data    = bus.host_writedata;
        bus.ram_wren    = host_grant & bus.host_write;
        if (core_grant) begin
            bus.ram_address = bus.core_address;
            bus.ram_data    = bus.core_wdata;
            bus.ram_wren    = bus.core_wren;
        end
    end

    // Last-grant memory and read owner tags for the one-cycle RAM latency
    always_ff @(posedge clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            last_grant  <= GNT_HOST;
            host_rd_tag <= 1'b0;
            core_rd_tag <= 1'b0;
        end else begin
            if (host_grant) begin
                last_grant <= GNT_HOST;
            end else if (core_grant) begin
                last_grant <= GNT_CORE;
            end
            host_rd_tag <= host_grant & bus.host_read & ~bus.host_write;
            core_rd_tag <= core_grant & ~bus.core_wren;
        end
    end

    assign bus.host_waitrequest   = host_req & ~host_grant;
    assign bus.core_gnt           = bus.core_req & core_grant;
    assign bus.host_readdatavalid = host_rd_tag;
    assign bus.core_rvalid        = core_rd_tag;
    assign bus.host_readdata      = bus.ram_q;
    assign bus.core_rdata         = bus.ram_q;
    assign bus.core_start         = core_start_q;

endmodule

// File: tb/tb_videocard_mem_arbiter.sv
// Directed bench for videocard_mem_arbiter with a small behavioural RAM
// (registered address, q one cycle after the address).
module tb_videocard_mem_arbiter;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    videocard_mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    videocard_mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .reset_sink_reset_n (rst_n),
        .bus                (bus)
    );

    // Behavioural 16-word RAM
    logic [WIDTH-1:0] mem [16];
    logic [3:0]       ram_addr_q;

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            mem[bus.ram_address[3:0]] <= bus.ram_data;
        end
        ram_addr_q <= bus.ram_address[3:0];
    end
    assign bus.ram_q = mem[ram_addr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic exp_core;

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        ram_addr_q = '0;
        rst_n = 1'b0;
        bus.host_address = '0; bus.host_writedata = '0;
        bus.host_write = 1'b0; bus.host_read = 1'b0;
        bus.core_req = 1'b0; bus.core_address = '0; bus.core_wdata = '0; bus.core_wren = 1'b0;
        bus.ctrl_address = 1'b1; bus.ctrl_write = 1'b0; bus.ctrl_writedata = '0;
        bus.core_done = 1'b0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_rdv", 32'(bus.host_readdatavalid), 0);
        chk("rst_crv", 32'(bus.core_rvalid), 0);
        chk("rst_start", 32'(bus.core_start), 0);
        chk("rst_status", bus.ctrl_readdata, 0);
        rst_n = 1'b1;

        // Host exclusive writes
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.host_write = 1'b1; bus.host_address = 16'(i); bus.host_writedata = 32'(i + 1);
            #1;
            chk("wr_wait", 32'(bus.host_waitrequest), 0);
            chk("wr_wren", 32'(bus.ram_wren), 1);
            chk("wr_addr", 32'(bus.ram_address), 32'(i));
            chk("wr_data", bus.ram_data, 32'(i + 1));
        end

        // Host back-to-back reads
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.host_write = 1'b0; bus.host_read = 1'b1; bus.host_address = 16'(i);
            #1;
            chk("rd_wait", 32'(bus.host_waitrequest), 0);
            chk("rd_wren", 32'(bus.ram_wren), 0);
            chk("rd_rdv", 32'(bus.host_readdatavalid), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("rd_data", bus.host_readdata, 32'(i));
        end
        tick(); bus.host_read = 1'b0; #1;
        chk("rd_rdv_last", 32'(bus.host_readdatavalid), 1);
        chk("rd_data_last", bus.host_readdata, 4);
        tick(); #1;
        chk("rd_rdv_off", 32'(bus.host_readdatavalid), 0);

        // Core locked out in IDLE
        tick();
        bus.core_req = 1'b1; bus.core_wren = 1'b1; bus.core_address = 16'd0; bus.core_wdata = 32'hDEAD;
        #1;
        chk("lock_gnt", 32'(bus.core_gnt), 0);
        chk("lock_wren", 32'(bus.ram_wren), 0);
        tick(); bus.core_req = 1'b0; bus.core_wren = 1'b0; bus.host_read = 1'b1; bus.host_address = 16'd0;
        tick(); bus.host_read = 1'b0; #1;
        chk("lock_rdv", 32'(bus.host_readdatavalid), 1);
        chk("lock_mem", bus.host_readdata, 1);

        // Start, then a repeated start during RUN
        tick(); bus.ctrl_write = 1'b1; bus.ctrl_address = 1'b0; bus.ctrl_writedata = 32'd1;
        tick(); bus.ctrl_write = 1'b0; bus.ctrl_address = 1'b1; #1;
        chk("start_pulse", 32'(bus.core_start), 1);
        chk("start_status", bus.ctrl_readdata, 1);
        tick(); bus.ctrl_write = 1'b1; bus.ctrl_address = 1'b0; #1;
        chk("start_fall", 32'(bus.core_start), 0);
        chk("addr0_read", bus.ctrl_readdata, 0);
        tick(); bus.ctrl_write = 1'b0; bus.ctrl_address = 1'b1; #1;
        chk("restart_nopulse", 32'(bus.core_start), 0);
        chk("restart_status", bus.ctrl_readdata, 1);

        // Contention in RUN
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.host_write = 1'b1; bus.host_address = 16'd8; bus.host_writedata = 32'h80 + 32'(i);
            bus.core_req = 1'b1; bus.core_wren = 1'b1; bus.core_address = 16'd9; bus.core_wdata = 32'h90 + 32'(i);
            #1;
`ifdef ARB_HOST_PRIORITY_EN
            exp_core = 1'b0;
`else
            exp_core = (i % 2 == 0);
`endif
            chk("cont_gnt", 32'(bus.core_gnt), 32'(exp_core));
            chk("cont_wait", 32'(bus.host_waitrequest), 32'(exp_core));
            chk("cont_addr", 32'(bus.ram_address), exp_core ? 32'd9 : 32'd8);
        end
        // Core alone in RUN, read back host's last write to addr 8
        tick(); bus.host_write = 1'b0; bus.core_wren = 1'b0; bus.core_address = 16'd8; #1;
        chk("core_solo_gnt", 32'(bus.core_gnt), 1);
        chk("core_solo_wait", 32'(bus.host_waitrequest), 0);
        tick(); bus.core_req = 1'b0; #1;
        chk("core_rvalid", 32'(bus.core_rvalid), 1);
        chk("core_rdata", bus.core_rdata, 32'h83);
        chk("core_rd_hostv", 32'(bus.host_readdatavalid), 0);
        tick(); #1;
        chk("core_rvalid_off", 32'(bus.core_rvalid), 0);

        // Done, acknowledge, done ignored in IDLE, restart
        tick(); bus.core_done = 1'b1;
        tick(); bus.core_done = 1'b0; #1;
        chk("done_status", bus.ctrl_readdata, 2);
        tick(); bus.ctrl_write = 1'b1; bus.ctrl_address = 1'b1; #1;
        chk("ack_status_pre", bus.ctrl_readdata, 2);
        tick(); bus.ctrl_write = 1'b0; #1;
        chk("ack_status", bus.ctrl_readdata, 0);
        tick(); bus.core_done = 1'b1;
        tick(); bus.core_done = 1'b0; #1;
        chk("idle_done_ign", bus.ctrl_readdata, 0);
        tick(); bus.ctrl_write = 1'b1; bus.ctrl_address = 1'b0; bus.ctrl_writedata = 32'd1;
        tick(); bus.ctrl_write = 1'b0; bus.ctrl_address = 1'b1; #1;
        chk("restart_pulse", 32'(bus.core_start), 1);
        chk("restart_run", bus.ctrl_readdata, 1);

        // Reset the cycle after a granted host read
        tick(); bus.host_read = 1'b1; bus.host_address = 16'd0; #1;
        chk("mid_wait", 32'(bus.host_waitrequest), 0);
        tick(); bus.host_read = 1'b0; rst_n = 1'b0; #1;
        chk("mid_rdv", 32'(bus.host_readdatavalid), 0);
        chk("mid_crv", 32'(bus.core_rvalid), 0);
        chk("mid_start", 32'(bus.core_start), 0);
        tick(); rst_n = 1'b1; #1;
        chk("mid_status", bus.ctrl_readdata, 0);
        chk("mid_rdv2", 32'(bus.host_readdatavalid), 0);
        tick(); bus.host_read = 1'b1; bus.host_address = 16'd3;
        tick(); bus.host_read = 1'b0; #1;
        chk("post_rdv", 32'(bus.host_readdatavalid), 1);
        chk("post_data", bus.host_readdata, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
